// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: one outstanding cache request, static next-PC prediction and a
// DEPTH-entry decode FIFO with redirect squash. Define MUNTJAC_IF_PERF_CNT_EN for perf counters.

typedef enum logic [2:0] {
  IF_PREFETCH,
  IF_PREDICT,
  IF_MISPREDICT,
  IF_PROT_CHANGED,
  IF_SATP_CHANGED,
  IF_FENCE_I,
  IF_SFENCE_VMA
} if_reason_e;

localparam logic [3:0] EXC_CAUSE_INSTR_PAGE_FAULT = 4'd12;

typedef struct packed {
  logic [3:0]  cause;
  logic [63:0] tval;
} exception_t;

typedef struct packed {
  logic [31:0] instr_word;
  logic [63:0] pc;
  if_reason_e  if_reason;
  logic        ex_valid;
  exception_t  exception;
} fetched_instr_t;

module instr_fetch_queue #(
  parameter int unsigned      XLEN        = 64,
  parameter int unsigned      DEPTH       = 4,
  parameter bit               BRANCH_PRED = 1'b1,
  parameter logic [XLEN-1:0]  RESET_PC    = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect_valid_i,
  input  logic [XLEN-1:0]          redirect_pc_i,
  input  if_reason_e               redirect_reason_i,
  input  logic [XLEN-1:0]          atp_i,
  input  logic                     prv_i,
  input  logic                     sum_i,
  output logic                     req_valid_o,
  input  logic                     req_ready_i,
  output logic [XLEN-1:0]          req_pc_o,
  output if_reason_e               req_reason_o,
  output logic [XLEN-1:0]          req_atp_o,
  output logic                     req_prv_o,
  output logic                     req_sum_o,
  input  logic                     resp_valid_i,
  input  logic [31:0]              resp_instr_i,
  input  logic                     resp_exception_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output fetched_instr_t           out_instr_o,
  output logic [$clog2(DEPTH):0]   occupancy_o
`ifdef MUNTJAC_IF_PERF_CNT_EN
  ,
  output logic [63:0]              perf_empty_stall_o,
  output logic [63:0]              perf_full_stall_o,
  output logic [63:0]              perf_flush_o
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

  state_e          state_q;
  logic            pend_valid_q;
  logic [XLEN-1:0] pend_pc_q;
  if_reason_e      pend_reason_q;
  logic [XLEN-1:0] atp_q;
  logic            prv_q;
  logic            sum_q;
  logic [PW-1:0]   wptr_q;
  logic [PW-1:0]   rptr_q;
  logic [CW-1:0]   count_q;

  logic [31:0]     instr_mem  [DEPTH];
  logic [XLEN-1:0] pc_mem     [DEPTH];
  if_reason_e      reason_mem [DEPTH];
  logic            ex_mem     [DEPTH];

  logic req_fire, enq, deq;

  // Issue only while a FIFO slot is free so the eventual response can always enqueue.
  assign req_valid_o  = !rst && (state_q == StIdle) && pend_valid_q && (count_q < CW'(DEPTH));
  assign req_fire     = req_valid_o && req_ready_i;
  assign req_pc_o     = pend_pc_q;
  assign req_reason_o = pend_reason_q;
  assign req_atp_o    = atp_q;
  assign req_prv_o    = prv_q;
  assign req_sum_o    = sum_q;

  assign enq         = (state_q == StWait) && resp_valid_i && !redirect_valid_i;
  assign out_valid_o = (count_q != '0);
  assign deq         = out_valid_o && out_ready_i;
  assign occupancy_o = count_q;

  always_comb begin
    out_instr_o                 = '0;
    out_instr_o.instr_word      = instr_mem[rptr_q];
    out_instr_o.pc              = 64'(pc_mem[rptr_q]);
    out_instr_o.if_reason       = reason_mem[rptr_q];
    out_instr_o.ex_valid        = ex_mem[rptr_q];
    out_instr_o.exception.cause = EXC_CAUSE_INSTR_PAGE_FAULT;
    out_instr_o.exception.tval  = 64'(pc_mem[rptr_q]);
  end

  // Static predictor: pend_pc_q still holds the PC of the in-flight request while in StWait.
  logic [XLEN-1:0] imm, npc, next_pc;
  logic            taken;

  always_comb begin
    imm   = '0;
    taken = 1'b0;
    if (resp_instr_i[1:0] == 2'b11) begin
      npc = pend_pc_q + XLEN'(4);
      if (resp_instr_i[6:0] == 7'b1100011) begin
        imm   = {{(XLEN-13){resp_instr_i[31]}}, resp_instr_i[31], resp_instr_i[7],
                 resp_instr_i[30:25], resp_instr_i[11:8], 1'b0};
        taken = resp_instr_i[31];
      end else if (resp_instr_i[6:0] == 7'b1101111) begin
        imm   = {{(XLEN-21){resp_instr_i[31]}}, resp_instr_i[31], resp_instr_i[19:12],
                 resp_instr_i[20], resp_instr_i[30:21], 1'b0};
        taken = 1'b1;
      end
    end else begin
      npc = pend_pc_q + XLEN'(2);
      if (resp_instr_i[1:0] == 2'b01) begin
        case (resp_instr_i[15:13])
          3'b101, 3'b001: begin
            imm   = {{(XLEN-12){resp_instr_i[12]}}, resp_instr_i[12], resp_instr_i[8],
                     resp_instr_i[10:9], resp_instr_i[6], resp_instr_i[7], resp_instr_i[2],
                     resp_instr_i[11], resp_instr_i[5:3], 1'b0};
            // Funct3 001 is c.jal only on RV32; on RV64 it encodes c.addiw.
            taken = (resp_instr_i[15:13] == 3'b101) || (XLEN == 32);
          end
          3'b110, 3'b111: begin
            imm   = {{(XLEN-9){resp_instr_i[12]}}, resp_instr_i[12], resp_instr_i[6:5],
                     resp_instr_i[2], resp_instr_i[11:10], resp_instr_i[4:3], 1'b0};
            taken = resp_instr_i[12];
          end
          default: ;
        endcase
      end
    end
    if (!BRANCH_PRED) taken = 1'b0;
    next_pc = taken ? pend_pc_q + imm : npc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      pend_valid_q  <= 1'b1;
      pend_pc_q     <= RESET_PC;
      pend_reason_q <= IF_FENCE_I;
      atp_q         <= '0;
      prv_q         <= 1'b0;
      sum_q         <= 1'b0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
    end else begin
      if (enq) begin
        instr_mem[wptr_q]  <= resp_instr_i;
        pc_mem[wptr_q]     <= pend_pc_q;
        reason_mem[wptr_q] <= pend_reason_q;
        ex_mem[wptr_q]     <= resp_exception_i;
        wptr_q             <= wptr_q + PW'(1);
      end
      if (deq) rptr_q <= rptr_q + PW'(1);
      count_q <= count_q + CW'(enq) - CW'(deq);

      unique case (state_q)
        StIdle: if (req_fire) begin
          state_q      <= StWait;
          pend_valid_q <= 1'b0;
        end
        StWait: if (resp_valid_i) begin
          state_q       <= StIdle;
          pend_valid_q  <= !resp_exception_i;
          pend_pc_q     <= next_pc;
          pend_reason_q <= taken ? IF_PREDICT : IF_PREFETCH;
        end
        StDrop: if (resp_valid_i) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase

      if (redirect_valid_i) begin
        wptr_q        <= '0;
        rptr_q        <= '0;
        count_q       <= '0;
        pend_valid_q  <= 1'b1;
        pend_pc_q     <= {redirect_pc_i[XLEN-1:1], 1'b0};
        pend_reason_q <= redirect_reason_i;
        atp_q         <= atp_i;
        prv_q         <= prv_i;
        sum_q         <= sum_i;
        // Any request still owed a response becomes stale.
        if ((state_q == StIdle && req_fire) || (state_q == StWait && !resp_valid_i)) begin
          state_q <= StDrop;
        end
      end
    end
  end

`ifdef MUNTJAC_IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_empty_stall_o <= '0;
      perf_full_stall_o  <= '0;
      perf_flush_o       <= '0;
    end else begin
      if (out_ready_i && !out_valid_o && !(&perf_empty_stall_o)) begin
        perf_empty_stall_o <= perf_empty_stall_o + 64'd1;
      end
      if (pend_valid_q && (count_q == CW'(DEPTH)) && !(&perf_full_stall_o)) begin
        perf_full_stall_o <= perf_full_stall_o + 64'd1;
      end
      if (redirect_valid_i && !(&perf_flush_o)) perf_flush_o <= perf_flush_o + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomised bench for instr_fetch_queue: the bench plays the cache and decode, and checks
// every cycle against a transaction-level model of requests and FIFO contents.

module tb_instr_fetch_queue;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned DEPTH  = 4;
  localparam logic [63:0] RST_PC = 64'h1000;
  localparam int          NCYC   = 3000;

  logic            clk;
  logic            rst;
  logic            redirect_valid_i;
  logic [63:0]     redirect_pc_i;
  if_reason_e      redirect_reason_i;
  logic [63:0]     atp_i;
  logic            prv_i;
  logic            sum_i;
  logic            req_valid_o;
  logic            req_ready_i;
  logic [63:0]     req_pc_o;
  if_reason_e      req_reason_o;
  logic [63:0]     req_atp_o;
  logic            req_prv_o;
  logic            req_sum_o;
  logic            resp_valid_i;
  logic [31:0]     resp_instr_i;
  logic            resp_exception_i;
  logic            out_valid_o;
  logic            out_ready_i;
  fetched_instr_t  out_instr_o;
  logic [2:0]      occupancy_o;
`ifdef MUNTJAC_IF_PERF_CNT_EN
  logic [63:0]     perf_empty_stall_o, perf_full_stall_o, perf_flush_o;
`endif

  instr_fetch_queue #(
    .XLEN        (XLEN),
    .DEPTH       (DEPTH),
    .BRANCH_PRED (1'b1),
    .RESET_PC    (RST_PC)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .redirect_valid_i  (redirect_valid_i),
    .redirect_pc_i     (redirect_pc_i),
    .redirect_reason_i (redirect_reason_i),
    .atp_i             (atp_i),
    .prv_i             (prv_i),
    .sum_i             (sum_i),
    .req_valid_o       (req_valid_o),
    .req_ready_i       (req_ready_i),
    .req_pc_o          (req_pc_o),
    .req_reason_o      (req_reason_o),
    .req_atp_o         (req_atp_o),
    .req_prv_o         (req_prv_o),
    .req_sum_o         (req_sum_o),
    .resp_valid_i      (resp_valid_i),
    .resp_instr_i      (resp_instr_i),
    .resp_exception_i  (resp_exception_i),
    .out_valid_o       (out_valid_o),
    .out_ready_i       (out_ready_i),
    .out_instr_o       (out_instr_o),
    .occupancy_o       (occupancy_o)
`ifdef MUNTJAC_IF_PERF_CNT_EN
    ,
    .perf_empty_stall_o (perf_empty_stall_o),
    .perf_full_stall_o  (perf_full_stall_o),
    .perf_flush_o       (perf_flush_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction table with hand-decoded control-flow effect (length, predicted taken, offset).
  logic [31:0] tbl_word [9] = '{32'h00000013, 32'h00000001, 32'hFE000EE3, 32'h00000463,
                                32'h0100006F, 32'hFF9FF06F, 32'h0000BFF5, 32'h0000DC75,
                                32'h0000E011};
  int          tbl_len  [9] = '{4, 2, 4, 4, 4, 4, 2, 2, 2};
  bit          tbl_taken[9] = '{0, 0, 1, 0, 1, 1, 1, 1, 0};
  longint      tbl_off  [9] = '{0, 0, -4, 0, 16, -8, -4, -4, 0};

  typedef struct {
    logic [31:0] w;
    logic [63:0] pc;
    if_reason_e  r;
    bit          ex;
  } ent_t;

  ent_t        mq[$];
  bit          m_pv;
  logic [63:0] m_pc;
  if_reason_e  m_reason;
  logic [63:0] m_atp;
  bit          m_prv, m_sum;
  bit          outstanding, stale;
  logic [63:0] fl_pc;
  if_reason_e  fl_reason;
  int          lat;
  int          cur_idx;
  bit          exp_rv;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1; redirect_valid_i = 1'b0; redirect_pc_i = '0; redirect_reason_i = IF_PREFETCH;
    atp_i = '0; prv_i = 1'b0; sum_i = 1'b0; req_ready_i = 1'b0; resp_valid_i = 1'b0;
    resp_instr_i = '0; resp_exception_i = 1'b0; out_ready_i = 1'b0;
    outstanding = 1'b0; stale = 1'b0; lat = 0; cur_idx = 0; m_pv = 1'b1; m_pc = RST_PC;
    m_reason = IF_FENCE_I; m_atp = '0; m_prv = 1'b0; m_sum = 1'b0; fl_pc = '0;
    fl_reason = IF_PREFETCH; exp_rv = 1'b0;

    for (int c = 0; c < NCYC; c++) begin
      bit in_a, in_b;
      logic [31:0] word;
      @(negedge clk);
      in_a = (c >= 2) && (c < 40);
      in_b = (c >= 40) && (c < 80);
      rst  = (c < 2) || (c == 1500);
      redirect_valid_i  = !rst && !in_a && !in_b && ($urandom_range(0, 29) == 0);
      redirect_pc_i     = {32'($urandom), 32'($urandom)};
      redirect_reason_i = if_reason_e'(3'($urandom_range(0, 6)));
      atp_i             = {32'($urandom), 32'($urandom)};
      prv_i             = 1'($urandom);
      sum_i             = 1'($urandom);
      req_ready_i       = (in_a || in_b) ? 1'b1 : ($urandom_range(0, 9) < 7);
      out_ready_i       = in_a ? 1'b1 : (in_b ? 1'b0 : ($urandom_range(0, 9) < 7));
      resp_valid_i      = 1'b0;
      resp_instr_i      = 32'($urandom);
      resp_exception_i  = 1'b0;
      if (!rst && outstanding) begin
        if (lat == 0) begin
          cur_idx = in_a ? 0 : $urandom_range(0, 8);
          word    = tbl_word[cur_idx];
          if (tbl_len[cur_idx] == 2) word[31:16] = 16'($urandom);
          resp_valid_i     = 1'b1;
          resp_instr_i     = word;
          resp_exception_i = !in_a && !in_b && ($urandom_range(0, 24) == 0);
        end else begin
          lat--;
        end
      end
      #1;

      exp_rv = !outstanding && m_pv && (mq.size() < DEPTH);
      if (rst) begin
        check_eq("req_valid_in_reset", 64'(req_valid_o), 64'(0));
      end else begin
        check_eq("req_valid", 64'(req_valid_o), 64'(exp_rv));
        if (exp_rv) begin
          check_eq("req_pc", req_pc_o, m_pc);
          check_eq("req_reason", 64'(req_reason_o), 64'(m_reason));
          check_eq("req_atp", req_atp_o, m_atp);
          check_eq("req_prv", 64'(req_prv_o), 64'(m_prv));
          check_eq("req_sum", 64'(req_sum_o), 64'(m_sum));
        end
        check_eq("out_valid", 64'(out_valid_o), 64'(mq.size() > 0));
        check_eq("occupancy", 64'(occupancy_o), 64'(mq.size()));
        if (mq.size() > 0) begin
          check_eq("out_word", 64'(out_instr_o.instr_word), 64'(mq[0].w));
          check_eq("out_pc", out_instr_o.pc, mq[0].pc);
          check_eq("out_reason", 64'(out_instr_o.if_reason), 64'(mq[0].r));
          check_eq("out_ex_valid", 64'(out_instr_o.ex_valid), 64'(mq[0].ex));
          if (mq[0].ex) begin
            check_eq("out_exc_cause", 64'(out_instr_o.exception.cause), 64'd12);
            check_eq("out_exc_tval", out_instr_o.exception.tval, mq[0].pc);
          end
        end
      end

      if (rst) begin
        mq.delete();
        m_pv = 1'b1; m_pc = RST_PC; m_reason = IF_FENCE_I;
        m_atp = '0; m_prv = 1'b0; m_sum = 1'b0;
        outstanding = 1'b0; stale = 1'b0;
      end else begin
        if ((mq.size() > 0) && out_ready_i) void'(mq.pop_front());
        if (resp_valid_i) begin
          outstanding = 1'b0;
          if (!stale && !redirect_valid_i) begin
            mq.push_back('{resp_instr_i, fl_pc, fl_reason, resp_exception_i});
            if (resp_exception_i) begin
              m_pv = 1'b0;
            end else if (tbl_taken[cur_idx]) begin
              m_pv = 1'b1; m_pc = fl_pc + tbl_off[cur_idx]; m_reason = IF_PREDICT;
            end else begin
              m_pv = 1'b1; m_pc = fl_pc + 64'(tbl_len[cur_idx]); m_reason = IF_PREFETCH;
            end
          end
          stale = 1'b0;
        end
        if (exp_rv && req_ready_i) begin
          outstanding = 1'b1; stale = 1'b0; m_pv = 1'b0;
          fl_pc = m_pc; fl_reason = m_reason;
          lat = (in_a || in_b) ? 0 : $urandom_range(0, 2);
        end
        if (redirect_valid_i) begin
          mq.delete();
          m_pc = redirect_pc_i & ~64'd1; m_reason = redirect_reason_i; m_pv = 1'b1;
          m_atp = atp_i; m_prv = prv_i; m_sum = sum_i;
          if (outstanding) stale = 1'b1;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Parametrised successor to the single-slot instruction fetcher.
- Sits between the compressed-aware icache front and decode.
- Issues one PC request at a time and predicts the next PC statically from each response.
- Buffers fetched instructions in a DEPTH-entry FIFO so decode stalls no longer back-pressure the cache response path.
- Supports redirect with squash of in-flight responses and of queued entries.

Parameters:
- XLEN, 64, address/PC width.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- BRANCH_PRED, 1, enables static prediction (backward branch taken, jal/c.j taken); 0 gives sequential next PC only.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- redirect_valid_i  in  1  flush and restart from redirect_pc_i.
- redirect_pc_i  in  XLEN  restart PC; bit 0 forced to 0.
- redirect_reason_i  in  if_reason_e  reason tagged on the first instruction after the redirect.
- atp_i  in  XLEN  translation root; sampled only on redirect.
- prv_i  in  1  privilege bit; sampled only on redirect.
- sum_i  in  1  SUM bit; sampled only on redirect.
- req_valid_o  out  1  cache request valid.
- req_ready_i  in  1  cache accepts request.
- req_pc_o  out  XLEN  request PC.
- req_reason_o  out  if_reason_e  request reason.
- req_atp_o  out  XLEN  latched translation root.
- req_prv_o  out  1  latched privilege bit.
- req_sum_o  out  1  latched SUM bit.
- resp_valid_i  in  1  cache response; exactly one per accepted request, in order.
- resp_instr_i  in  32  instruction word.
- resp_exception_i  in  1  page fault on fetch.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  decode accepts head.
- out_instr_o  out  fetched_instr_t  head entry: instr_word, pc, if_reason, ex_valid, exception (cause EXC_CAUSE_INSTR_PAGE_FAULT, tval = pc).
- occupancy_o  out  $clog2(DEPTH)+1  current FIFO entry count.

Behaviour:
- Reset (rst=1 at a clock edge):
  - FIFO empty; out_valid_o=0; occupancy_o=0.
  - pend_valid=1, pend_pc=RESET_PC, pend_reason=IF_FENCE_I.
  - atp/prv/sum latches = 0.
  - FSM=IDLE; req_valid_o=0 during reset.
  - Reset mid-transaction discards everything; the cache is reset on the same rst.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: one live request outstanding.
  - DROP: one stale request outstanding.
- Issue rule: req_valid_o = (FSM==IDLE) && pend_valid && (occupancy_o < DEPTH). The single in-flight slot is reserved so a response can always enqueue.
- IDLE to WAIT on req_valid_o && req_ready_i; pend_valid clears.
- WAIT: on resp_valid_i:
  - Enqueue {instr, pc, reason, ex}.
  - Compute next PC: predicted target if predict_taken (reason IF_PREDICT), else npc (reason IF_PREFETCH).
  - npc = pc+4 if instr[1:0]==11, else pc+2.
  - If ex=1, no next PC: pend_valid stays 0 until a redirect.
  - Return to IDLE. Back-to-back issue on the next cycle is allowed; zero-cycle issue from the response is not required.
- Redirect (redirect_valid_i=1):
  - Next cycle: FIFO empty.
  - pend_pc={redirect_pc_i[XLEN-1:1],0}; pend_reason=redirect_reason_i; pend_valid=1.
  - atp/prv/sum latched.
  - FSM WAIT goes to DROP; IDLE stays IDLE.
  - A req handshake in the same cycle as the redirect is treated as stale: the FSM goes to DROP.
- DROP: on resp_valid_i, discard the response and go to IDLE. A redirect while in DROP updates pend_* only.
- Redirect has priority over a same-cycle enqueue and dequeue; the dequeue still completes at the consumer side.
- A same-cycle enqueue and dequeue with the FIFO full is legal only through the reserved slot; occupancy is unchanged.
- Dequeue on out_valid_o && out_ready_i. Head fields are registered, with no combinational path from resp_* to out_*.
- Pointers are $clog2(DEPTH) bits and wrap naturally; full/empty are derived from occupancy.
- Predicted target arithmetic is XLEN-bit modulo 2^XLEN. Immediate decoding is identical to the existing fetcher's branch/jal/c.beqz/c.bnez/c.j/c.jal rules.
- Redirect latency: first request for the redirect PC appears 1 cycle after redirect (from IDLE), or 1 cycle after the stale response (from DROP).

Optional Feature:
- MUNTJAC_IF_PERF_CNT_EN defined: adds outputs perf_empty_stall_o (64-bit, cycles with out_ready_i && !out_valid_o), perf_full_stall_o (64-bit, cycles with pend_valid && occupancy_o==DEPTH), and perf_flush_o (64-bit, redirect count). All three clear on rst and saturate at all-ones.
- Not defined: these ports and counters are absent.

Test Plan:
- Reset, RESET_PC=0x1000, cache always ready, 1-cycle response of addi (0x00000013): requests at 0x1000, 0x1004, 0x1008; out entries carry reasons FENCE_I, PREFETCH, PREFETCH.
- Response 0xFE000EE3 (beq x0,x0,-4) at 0x2000 -> next req_pc_o=0x1FFC, reason IF_PREDICT. With BRANCH_PRED=0 -> 0x2004.
- Compressed word 0x0001 at 0x3002 -> next req 0x3004. Word 0x00000013 at 0x3002 -> next req 0x3006.
- out_ready_i=0, DEPTH=4: exactly 4 entries buffered, no 5th request issued. Raise out_ready_i -> in-order drain, then fetching resumes.
- Redirect to 0x8001 while a request is outstanding: the stale response is dropped, the FIFO empties next cycle, and the next req_pc_o=0x8000 with the redirect reason and new atp/prv/sum.
- resp_exception_i=1 at 0x4000 -> entry ex_valid=1, tval=0x4000; no further requests until a redirect.
